// File: rtl/sram_like_slave_pkg.sv
// rtl/sram_like_slave_pkg.sv - shared encodings, bus widths and parameter bounds for sram_like_slave
package sram_like_slave_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_e;

  localparam int ADDR_BUS_W = 32;
  localparam int DATA_W     = 32;
  localparam int STRB_W     = 4;

  localparam int LAT_MIN         = 1;
  localparam int LAT_MAX         = 8;
  localparam int OUTSTANDING_MIN = 1;
  localparam int OUTSTANDING_MAX = 8;

  // Wide enough to count 0..OUTSTANDING_MAX inclusive.
  localparam int INFLIGHT_W = $clog2(OUTSTANDING_MAX + 1);

endpackage

// File: rtl/sram_like_slave_dsram_bank.sv
// rtl/sram_like_slave_dsram_bank.sv - single-port word array, byte-lane writes, synchronous read
module dsram_bank
  import sram_like_slave_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Contents are deliberately never reset so stores survive a controller reset.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < STRB_W; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        q <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/sram_like_slave.sv
// rtl/sram_like_slave.sv - pipelined SRAM-like slave: handshake, in-flight counter, LAT-stage response line
module sram_like_slave
  import sram_like_slave_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int LAT         = 2,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [3:0]  wstrb,
  input  logic [31:0] wdata,
  input  logic        hold,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam logic [INFLIGHT_W-1:0] OUTSTANDING_CNT = INFLIGHT_W'(OUTSTANDING);
  localparam logic [INFLIGHT_W-1:0] ONE_CNT         = INFLIGHT_W'(1);

  logic                  accept;
  logic [INFLIGHT_W-1:0] inflight;
  logic                  head_v;
  logic                  head_ld;
  logic [DATA_W-1:0]     bank_q;
  logic [DATA_W-1:0]     head_d;
  logic                  tail_v;
  logic [DATA_W-1:0]     tail_d;
  logic [DATA_W-1:0]     last_d;
  size_e                 size_q;

  assign accept  = req && addr_ok && !reset;
  assign addr_ok = !hold && ((inflight < OUTSTANDING_CNT) || data_ok);

  // Masking with reset keeps a response due in the reset cycle from escaping.
  assign data_ok = tail_v && !reset;
  assign rdata   = data_ok ? tail_d : last_d;

  dsram_bank #(
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk  (clk),
    .en   (accept),
    .we   (wr),
    .idx  (addr[ADDR_W+1:2]),
    .be   (wstrb),
    .wdata(wdata),
    .q    (bank_q)
  );

  // Stage 0 of the response line: the bank output register carries the load data.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_v  <= 1'b0;
      head_ld <= 1'b0;
      size_q  <= SIZE_WORD;
    end else begin
      head_v  <= accept;
      head_ld <= accept && !wr;
      if (accept) size_q <= size_e'(size);
    end
  end

  assign head_d = head_ld ? bank_q : '0;

  generate
    if (LAT == 1) begin : g_lat1
      assign tail_v = head_v;
      assign tail_d = head_d;
    end else begin : g_latn
      logic [LAT-1:1]    v_q;
      logic [DATA_W-1:0] d_q [1:LAT-1];

      always_ff @(posedge clk) begin
        if (reset) begin
          v_q <= '0;
        end else begin
          v_q[1] <= head_v;
          for (int k = 2; k < LAT; k++) v_q[k] <= v_q[k-1];
        end
      end

      always_ff @(posedge clk) begin
        d_q[1] <= head_d;
        for (int k = 2; k < LAT; k++) d_q[k] <= d_q[k-1];
      end

      assign tail_v = v_q[LAT-1];
      assign tail_d = d_q[LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else if (accept && !data_ok) begin
      inflight <= inflight + ONE_CNT;
    end else if (!accept && data_ok) begin
      inflight <= inflight - ONE_CNT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_d <= '0;
    end else if (data_ok) begin
      last_d <= tail_d;
    end
  end

  // Byte offset, aliased upper address bits and the recorded size never reach the array.
  logic unused_ok;
  assign unused_ok = ^{addr[1:0], addr[31:ADDR_W+2], size_q};

endmodule
